traffic_light_monitor: RTL and testbench
========================================

TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

Interface
REQ-001 Parameter RED_CYCLES, default 50, expected RED dwell in clock cycles (1..65534).
REQ-002 Parameter GREEN_CYCLES, default 40, expected GREEN dwell in clock cycles (1..65534).
REQ-003 Parameter YELLOW_CYCLES, default 10, expected YELLOW dwell in clock cycles (1..65534).
REQ-004 Parameter TOL, default 0, allowed +/- dwell deviation in cycles; each EXPECTED+TOL SHALL be at most 65534.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 red  input  1  observed red lamp, synchronous to clk.
REQ-008 yellow  input  1  observed yellow lamp, synchronous to clk.
REQ-009 green  input  1  observed green lamp, synchronous to clk.
REQ-010 phase  output  2  tracked phase: 0 UNKNOWN, 1 RED, 2 GREEN, 3 YELLOW.
REQ-011 err_illegal  output  1  one-cycle pulse: lamp vector not one-hot.
REQ-012 err_order  output  1  one-cycle pulse: legal but out-of-sequence transition.
REQ-013 err_timing  output  1  one-cycle pulse: phase dwell outside EXPECTED+/-TOL.
REQ-014 err_any  output  1  sticky OR of all error pulses.
REQ-015 cycle_cnt  output  8  count of completed legal RED->GREEN->YELLOW->RED rounds.

Function
REQ-016 Lamps SHALL be sampled on every rising edge; every output SHALL be registered and reflect that sample in the following cycle.
REQ-017 Legal sequence SHALL be RED -> GREEN -> YELLOW -> RED.
REQ-018 Internal 16-bit dwell counter: set to 1 on phase entry, +1 on each edge with the same legal vector, saturating at 65535.
REQ-019 Non-one-hot sample (none or >=2 lamps) SHALL pulse err_illegal, set phase to UNKNOWN, clear dwell; each illegal sample pulses again.
REQ-020 From UNKNOWN, any legal sample SHALL be adopted as phase with no order or timing check; the timing check SHALL be disabled for that first (partial) phase.
REQ-021 Legal sample differing from phase, not the legal successor: pulse err_order, adopt new phase, dwell=1, timing check for the new phase enabled.
REQ-022 On any legal->legal transition with timing check enabled: if dwell < EXPECTED-TOL (floored at 1) or dwell > EXPECTED+TOL of the departing phase, pulse err_timing, unless already flagged per REQ-023.
REQ-023 Overstay: when dwell reaches EXPECTED+TOL+1 while still in the phase, pulse err_timing once; no second timing pulse for that phase.
REQ-024 err_order and err_timing MAY pulse on the same edge; err_illegal SHALL suppress both on its edge.
REQ-025 cycle_cnt SHALL increment on a YELLOW->RED transition only if the preceding RED->GREEN and GREEN->YELLOW transitions were both in-order with no illegal sample in between; wraps 255->0.
REQ-026 err_any SHALL set on any error pulse and clear only by reset.

Reset
REQ-027 reset_n low SHALL immediately force phase=0, all err_* =0, cycle_cnt=0, dwell=0, timing check disabled, independent of clk.
REQ-028 Reset asserted mid-phase SHALL discard the phase; the first sample after release is treated as from UNKNOWN.

Verification (RED_CYCLES=5, GREEN_CYCLES=4, YELLOW_CYCLES=2, TOL=0)
REQ-029 Reset release, then RED x5, GREEN x4, YELLOW x2, RED: no error pulses, phase tracks 1,2,3,1; cycle_cnt=0 (first RED partial) after first round; cycle_cnt=1 after second full round.
REQ-030 Legal lamps 1 cycle at red+green=1 mid-GREEN: one err_illegal pulse, phase=0, err_any=1; following GREEN adopted with no further errors.
REQ-031 GREEN -> RED directly: err_order pulse, phase=1, cycle_cnt unchanged.
REQ-032 GREEN held 3 cycles then YELLOW: err_timing pulse; GREEN held 10 cycles: exactly one err_timing pulse after 5th GREEN sample, none on exit.
REQ-033 reset_n pulled low between clock edges during YELLOW: outputs zero before next edge; after release YELLOW x1 then RED: no timing or order error.
REQ-034 Run 256 clean rounds: cycle_cnt wraps to 0 (+1 for partial start accounted), err_any stays 0.

Source files
------------

// File: rtl/traffic_light_monitor.sv
// Traffic light sequence monitor: tracks the observed lamp phase and flags illegal lamp
// vectors, out-of-order transitions and dwell-time violations; counts clean rounds.
module traffic_light_monitor #(
  parameter int unsigned RED_CYCLES    = 50,
  parameter int unsigned GREEN_CYCLES  = 40,
  parameter int unsigned YELLOW_CYCLES = 10,
  parameter int unsigned TOL           = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       red,
  input  logic       yellow,
  input  logic       green,
  output logic [1:0] phase,
  output logic       err_illegal,
  output logic       err_order,
  output logic       err_timing,
  output logic       err_any,
  output logic [7:0] cycle_cnt
);

  typedef enum logic [1:0] {
    PhUnknown = 2'd0,
    PhRed     = 2'd1,
    PhGreen   = 2'd2,
    PhYellow  = 2'd3
  } phase_e;

  // Dwell window bounds; the lower bound never drops below one cycle.
  localparam logic [15:0] RedHi    = 16'(RED_CYCLES + TOL);
  localparam logic [15:0] GreenHi  = 16'(GREEN_CYCLES + TOL);
  localparam logic [15:0] YellowHi = 16'(YELLOW_CYCLES + TOL);
  localparam logic [15:0] RedLo    = (RED_CYCLES > TOL) ? 16'(RED_CYCLES - TOL) : 16'd1;
  localparam logic [15:0] GreenLo  = (GREEN_CYCLES > TOL) ? 16'(GREEN_CYCLES - TOL) : 16'd1;
  localparam logic [15:0] YellowLo = (YELLOW_CYCLES > TOL) ? 16'(YELLOW_CYCLES - TOL) : 16'd1;

  phase_e      phase_q, phase_d;
  logic [15:0] dwell_q, dwell_d;
  logic        tchk_q, tchk_d;
  logic        flagged_q, flagged_d;
  logic        rg_q, rg_d;
  logic        gy_q, gy_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        ill_q, ill_d;
  logic        ord_q, ord_d;
  logic        tim_q, tim_d;
  logic        any_q, any_d;

  logic        one_hot;
  phase_e      samp;
  phase_e      succ;
  logic [15:0] exp_lo, exp_hi;
  logic        in_order;

  always_comb begin
    one_hot = $onehot({red, yellow, green});
    samp    = red ? PhRed : (green ? PhGreen : PhYellow);

    succ   = PhUnknown;
    exp_lo = RedLo;
    exp_hi = RedHi;
    unique case (phase_q)
      PhRed: begin
        succ   = PhGreen;
        exp_lo = RedLo;
        exp_hi = RedHi;
      end
      PhGreen: begin
        succ   = PhYellow;
        exp_lo = GreenLo;
        exp_hi = GreenHi;
      end
      PhYellow: begin
        succ   = PhRed;
        exp_lo = YellowLo;
        exp_hi = YellowHi;
      end
      default: ;
    endcase
  end

  always_comb begin
    phase_d   = phase_q;
    dwell_d   = dwell_q;
    tchk_d    = tchk_q;
    flagged_d = flagged_q;
    rg_d      = rg_q;
    gy_d      = gy_q;
    cnt_d     = cnt_q;
    ill_d     = 1'b0;
    ord_d     = 1'b0;
    tim_d     = 1'b0;
    in_order  = (samp == succ);

    if (!one_hot) begin
      ill_d     = 1'b1;
      phase_d   = PhUnknown;
      dwell_d   = 16'd0;
      tchk_d    = 1'b0;
      flagged_d = 1'b0;
      rg_d      = 1'b0;
      gy_d      = 1'b0;
    end else if (phase_q == PhUnknown) begin
      phase_d   = samp;
      dwell_d   = 16'd1;
      tchk_d    = 1'b0;
      flagged_d = 1'b0;
      rg_d      = 1'b0;
      gy_d      = 1'b0;
    end else if (samp == phase_q) begin
      if (dwell_q != 16'hFFFF) dwell_d = dwell_q + 16'd1;
      // Overstay fires as the dwell steps from the upper bound to one past it.
      if (tchk_q && !flagged_q && dwell_q == exp_hi) begin
        tim_d     = 1'b1;
        flagged_d = 1'b1;
      end
    end else begin
      ord_d = !in_order;
      if (tchk_q && !flagged_q && (dwell_q < exp_lo || dwell_q > exp_hi)) tim_d = 1'b1;
      if (in_order) begin
        unique case (phase_q)
          PhRed: begin
            // A RED adopted from unknown is partial and cannot open a round.
            rg_d = tchk_q;
            gy_d = 1'b0;
          end
          PhGreen: gy_d = rg_q;
          PhYellow: begin
            if (rg_q && gy_q) cnt_d = cnt_q + 8'd1;
            rg_d = 1'b0;
            gy_d = 1'b0;
          end
          default: ;
        endcase
      end else begin
        rg_d = 1'b0;
        gy_d = 1'b0;
      end
      phase_d   = samp;
      dwell_d   = 16'd1;
      tchk_d    = 1'b1;
      flagged_d = 1'b0;
    end

    any_d = any_q | ill_d | ord_d | tim_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q   <= PhUnknown;
      dwell_q   <= 16'd0;
      tchk_q    <= 1'b0;
      flagged_q <= 1'b0;
      rg_q      <= 1'b0;
      gy_q      <= 1'b0;
      cnt_q     <= 8'd0;
      ill_q     <= 1'b0;
      ord_q     <= 1'b0;
      tim_q     <= 1'b0;
      any_q     <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      dwell_q   <= dwell_d;
      tchk_q    <= tchk_d;
      flagged_q <= flagged_d;
      rg_q      <= rg_d;
      gy_q      <= gy_d;
      cnt_q     <= cnt_d;
      ill_q     <= ill_d;
      ord_q     <= ord_d;
      tim_q     <= tim_d;
      any_q     <= any_d;
    end
  end

  assign phase       = phase_q;
  assign err_illegal = ill_q;
  assign err_order   = ord_q;
  assign err_timing  = tim_q;
  assign err_any     = any_q;
  assign cycle_cnt   = cnt_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor: per-cycle comparison against a phase-entry
// history model plus literal expectations for each scenario.
module tb_traffic_light_monitor;

  localparam int RedN    = 5;
  localparam int GreenN  = 4;
  localparam int YellowN = 2;
  localparam int Tol     = 0;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       red = 1'b0, yellow = 1'b0, green = 1'b0;
  logic [1:0] phase;
  logic       err_illegal, err_order, err_timing, err_any;
  logic [7:0] cycle_cnt;

  int errors = 0;
  int checks = 0;

  traffic_light_monitor #(
    .RED_CYCLES   (RedN),
    .GREEN_CYCLES (GreenN),
    .YELLOW_CYCLES(YellowN),
    .TOL          (Tol)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .red        (red),
    .yellow     (yellow),
    .green      (green),
    .phase      (phase),
    .err_illegal(err_illegal),
    .err_order  (err_order),
    .err_timing (err_timing),
    .err_any    (err_any),
    .cycle_cnt  (cycle_cnt)
  );

  always #5 clk = ~clk;

  // Model: phase history as a list of entries (phase, how it was entered).
  // kind: 0 adopted from unknown, 1 in-order transition, 2 out-of-order transition.
  int m_phase = 0, m_dwell = 0, m_checked = 0, m_flagged = 0, m_cnt = 0;
  int m_ill = 0, m_ord = 0, m_tim = 0, m_any = 0;
  int e_ph[$];
  int e_kind[$];

  function automatic int exp_of(int p);
    return (p == 1) ? RedN : (p == 2) ? GreenN : YellowN;
  endfunction

  function automatic int lo_of(int p);
    return (exp_of(p) > Tol) ? exp_of(p) - Tol : 1;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_phase = 0; m_dwell = 0; m_checked = 0; m_flagged = 0; m_cnt = 0;
      m_ill = 0; m_ord = 0; m_tim = 0; m_any = 0;
      e_ph.delete(); e_kind.delete();
    end else begin
      int n, p, k;
      n = int'(red) + int'(yellow) + int'(green);
      p = red ? 1 : (green ? 2 : 3);
      m_ill = 0; m_ord = 0; m_tim = 0;
      if (n != 1) begin
        m_ill = 1; m_phase = 0; m_dwell = 0; m_checked = 0; m_flagged = 0;
        e_ph.delete(); e_kind.delete();
      end else if (m_phase == 0) begin
        m_phase = p; m_dwell = 1; m_checked = 0; m_flagged = 0;
        e_ph.push_back(p); e_kind.push_back(0);
      end else if (p == m_phase) begin
        if (m_dwell < 65535) m_dwell++;
        if (m_checked != 0 && m_flagged == 0 && m_dwell == exp_of(p) + Tol + 1) begin
          m_tim = 1; m_flagged = 1;
        end
      end else begin
        m_ord = (p == (m_phase % 3) + 1) ? 0 : 1;
        if (m_checked != 0 && m_flagged == 0 &&
            (m_dwell < lo_of(m_phase) || m_dwell > exp_of(m_phase) + Tol)) m_tim = 1;
        e_ph.push_back(p); e_kind.push_back(m_ord ? 2 : 1);
        if (e_ph.size() > 4) begin
          void'(e_ph.pop_front()); void'(e_kind.pop_front());
        end
        k = e_ph.size();
        if (k == 4 && e_ph[0] == 1 && e_kind[0] != 0 &&
            e_ph[1] == 2 && e_kind[1] == 1 && e_ph[2] == 3 && e_kind[2] == 1 &&
            e_ph[3] == 1 && e_kind[3] == 1) m_cnt = (m_cnt + 1) % 256;
        m_phase = p; m_dwell = 1; m_checked = 1; m_flagged = 0;
      end
      if (m_ill != 0 || m_ord != 0 || m_tim != 0) m_any = 1;
    end
  end

  always @(negedge clk) begin
    logic [13:0] act, expv;
    act  = {phase, err_illegal, err_order, err_timing, err_any, cycle_cnt};
    expv = {m_phase[1:0], m_ill[0], m_ord[0], m_tim[0], m_any[0], m_cnt[7:0]};
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL model_cmp t=%0t got=%b want=%b", $time, act, expv);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, act, want);
    end
  endtask

  task automatic apply(input logic r, input logic y, input logic g, input int n);
    for (int i = 0; i < n; i++) begin
      red = r; yellow = y; green = g;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    chk("reset_outputs_zero", {18'd0, phase, err_illegal, err_order, err_timing, err_any,
                               cycle_cnt}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #12;
    chk("reset_state", {18'd0, phase, err_illegal, err_order, err_timing, err_any,
                        cycle_cnt}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Clean rounds: the first RED is partial and does not count.
    apply(1, 0, 0, 5);  chk("r1_phase_red", phase, 1);
    apply(0, 0, 1, 4);  chk("r1_phase_green", phase, 2);
    apply(0, 1, 0, 2);  chk("r1_phase_yellow", phase, 3);
    apply(1, 0, 0, 1);  chk("r1_phase_red2", phase, 1);
    chk("r1_cnt", cycle_cnt, 0);
    apply(1, 0, 0, 4);
    apply(0, 0, 1, 4);
    apply(0, 1, 0, 2);
    apply(1, 0, 0, 1);
    chk("r2_cnt", cycle_cnt, 1);
    chk("r2_any", err_any, 0);

    // Illegal lamp vectors mid-GREEN.
    apply(1, 0, 0, 4);
    apply(0, 0, 1, 2);
    apply(1, 0, 1, 1);
    chk("ill_pulse", err_illegal, 1);
    chk("ill_phase", phase, 0);
    chk("ill_any", err_any, 1);
    apply(0, 0, 0, 1);  chk("ill_again", err_illegal, 1);
    apply(0, 0, 1, 1);
    chk("ill_adopt", {phase, err_illegal, err_order, err_timing}, 5'b10_000);
    apply(0, 0, 1, 2);
    apply(0, 1, 0, 2);
    chk("ill_partial_exit", {phase, err_order, err_timing}, 4'b11_00);
    apply(1, 0, 0, 1);
    chk("ill_cnt_kept", cycle_cnt, 1);

    // Out-of-order GREEN -> RED.
    do_reset();
    apply(1, 0, 0, 1);
    apply(0, 0, 1, 4);
    apply(1, 0, 0, 1);
    chk("ord_pulse", err_order, 1);
    chk("ord_no_timing", err_timing, 0);
    chk("ord_phase", phase, 1);
    chk("ord_cnt", cycle_cnt, 0);

    // Short GREEN, then overstayed GREEN.
    do_reset();
    apply(0, 1, 0, 1);
    apply(1, 0, 0, 5);
    apply(0, 0, 1, 3);
    apply(0, 1, 0, 1);
    chk("short_timing", err_timing, 1);
    chk("short_order", err_order, 0);
    apply(0, 1, 0, 1);
    apply(1, 0, 0, 5);
    apply(0, 0, 1, 4);  chk("long_at4", err_timing, 0);
    apply(0, 0, 1, 1);  chk("long_at5", err_timing, 1);
    for (int i = 0; i < 5; i++) begin
      apply(0, 0, 1, 1);
      chk("long_no_repeat", err_timing, 0);
    end
    apply(0, 1, 0, 1);
    chk("long_exit", err_timing, 0);

    // Reset during YELLOW; restart treated as from unknown.
    do_reset();
    apply(1, 0, 0, 1);
    apply(0, 0, 1, 4);
    apply(0, 1, 0, 1);
    #2;
    do_reset();
    apply(0, 1, 0, 1);
    apply(1, 0, 0, 1);
    chk("rst_restart", {phase, err_order, err_timing, err_any}, 5'b01_000);

    // Counter wrap: partial start plus 256 complete rounds.
    do_reset();
    apply(1, 0, 0, 1);
    for (int i = 0; i < 256; i++) begin
      apply(0, 0, 1, 4);
      apply(0, 1, 0, 2);
      apply(1, 0, 0, 5);
    end
    chk("wrap_255", cycle_cnt, 255);
    apply(0, 0, 1, 4);
    apply(0, 1, 0, 2);
    apply(1, 0, 0, 1);
    chk("wrap_0", cycle_cnt, 0);
    chk("wrap_any", err_any, 0);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
